// File: rtl/apb_slv_ctrl_pkg.sv
// Shared APB-side widths, status record and helpers for the bridge's slave controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_slv_ctrl_pkg;

    localparam int PADDR_WIDTH       = 32;
    localparam int APB_DATA_WIDTH    = 32;
    localparam int APB_SLV_IDX_WIDTH = 2;
    localparam int ERR_CNT_WIDTH     = 8;

    // Software-visible sticky error status.
    typedef struct packed {
        logic [ERR_CNT_WIDTH-1:0] err_cnt;
        logic [PADDR_WIDTH-1:0]   err_addr;
        logic                     to_flag;
    } stat_t;

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/apb_slv_ctrl_if.sv
// Bundles the bridge-facing and slave-facing APB signals of the slave controller.
// Latency: n/a (wires only).
// Backpressure: pready_x / pready_s carry the APB wait-state handshake.
//
// Ports (modport slave = controller view):
//   bridge side : psel_en, penable, paddr (in); pready_x, pslverr_x, prdata_x (out)
//   slave side  : psel_s, penable_s (out); pready_s, pslverr_s, prdata_s (in, slave i at [i*W +: W])
interface apb_slv_ctrl_if #(
    parameter int SLV_NUM = 4
) ();
    import apb_slv_ctrl_pkg::*;

    logic                              psel_en;
    logic                              penable;
    logic [PADDR_WIDTH-1:0]            paddr;
    logic                              pready_x;
    logic                              pslverr_x;
    logic [APB_DATA_WIDTH-1:0]         prdata_x;
    logic [SLV_NUM-1:0]                psel_s;
    logic                              penable_s;
    logic [SLV_NUM-1:0]                pready_s;
    logic [SLV_NUM-1:0]                pslverr_s;
    logic [SLV_NUM*APB_DATA_WIDTH-1:0] prdata_s;

    // Bridge plus attached slaves: everything that surrounds the controller.
    modport master (
        output psel_en, penable, paddr, pready_s, pslverr_s, prdata_s,
        input  pready_x, pslverr_x, prdata_x, psel_s, penable_s
    );

    // The controller itself.
    modport slave (
        input  psel_en, penable, paddr, pready_s, pslverr_s, prdata_s,
        output pready_x, pslverr_x, prdata_x, psel_s, penable_s
    );

endinterface

// File: rtl/apb_slv_ctrl_timeout_cnt.sv
// Saturating counter of access-phase cycles spent waiting on a slave.
// Latency: expire is combinational from the registered count.
// Backpressure: none; counts while inc is high, clr has priority.
//
// Ports: hclk, hreset_n (sync, active-low), clr, inc, expire.
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic hclk,
    input  logic hreset_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    generate
        if (TIMEOUT_CYC > 0) begin : g_on
            localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
            localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
            localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(TIMEOUT_CYC - 1);

            logic [CNT_W-1:0] to_cnt;

            always_ff @(posedge hclk) begin
                if (!hreset_n || clr) begin
                    to_cnt <= '0;
                end else if (inc && (to_cnt != CNT_MAX)) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end

            // Count equals TIMEOUT_CYC-1 during the TIMEOUT_CYC-th waiting cycle.
            assign expire = (to_cnt == CNT_EXP);
        end else begin : g_off
            logic unused_inputs;
            assign unused_inputs = &{1'b0, hclk, hreset_n, clr, inc};
            assign expire        = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/apb_slv_ctrl.sv
// APB-side controller of the AHB-to-APB bridge: decodes paddr to a slave select,
// tracks setup/access, returns the slave response and keeps sticky error status.
// Latency: zero added wait states; response path is combinational from the slave.
// Backpressure: slave pready_s is passed through; an unmapped address or a slave
// that stalls for TIMEOUT_CYC access cycles is completed with an error instead.
//
// Ports: hclk, hreset_n (sync, active-low), bus (apb_slv_ctrl_if.slave),
//        stat_clr (in), err_cnt / err_addr / to_flag (status out).
module apb_slv_ctrl
    import apb_slv_ctrl_pkg::*;
#(
    parameter int SLV_NUM      = 4,
    parameter int SLV_ADDR_LSB = 12,
    parameter int TIMEOUT_CYC  = 16
) (
    input  logic                     hclk,
    input  logic                     hreset_n,
    apb_slv_ctrl_if.slave            bus,
    input  logic                     stat_clr,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [PADDR_WIDTH-1:0]   err_addr,
    output logic                     to_flag
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]                   state;
    logic [1:0]                   state_nxt;
    logic [APB_SLV_IDX_WIDTH-1:0] idx;
    logic                         upper_zero;
    logic                         mapped;
    logic                         access_en;
    logic                         sel_rdy;
    logic                         sel_err;
    logic [APB_DATA_WIDTH-1:0]    sel_dat;
    logic                         rsp_rdy;
    logic                         rsp_err;
    logic [APB_DATA_WIDTH-1:0]    rsp_dat;
    logic                         to_hit;
    logic                         expire;
    logic                         err_done;
    stat_t                        stat_q;

    // ---------------- address decode ----------------
    assign idx        = bus.paddr[SLV_ADDR_LSB +: APB_SLV_IDX_WIDTH];
    assign upper_zero = ((bus.paddr >> (SLV_ADDR_LSB + APB_SLV_IDX_WIDTH)) == '0);
    assign mapped     = upper_zero && (32'(idx) < SLV_NUM);

    // Slave response mux; an out-of-range index never reaches a slave vector bit.
    always_comb begin
        sel_rdy = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        for (int i = 0; i < SLV_NUM; i++) begin
            if (32'(idx) == i) begin
                sel_rdy = bus.pready_s[i];
                sel_err = bus.pslverr_s[i];
                sel_dat = bus.prdata_s[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        bus.psel_s = '0;
        for (int i = 0; i < SLV_NUM; i++) begin
            bus.psel_s[i] = bus.psel_en && mapped && (state != ST_IDLE) && (32'(idx) == i);
        end
    end

    assign bus.penable_s = bus.penable && mapped && (state == ST_ACCESS);

    // ---------------- completion ----------------
    assign access_en = (state == ST_ACCESS) && bus.penable;

    // Priority: unmapped error, then slave ready, then timeout. A slave that
    // answers in the expiring cycle wins, so no timeout is recorded then.
    always_comb begin
        rsp_rdy = 1'b0;
        rsp_err = 1'b0;
        rsp_dat = '0;
        to_hit  = 1'b0;
        if (access_en) begin
            if (!mapped) begin
                rsp_rdy = 1'b1;
                rsp_err = 1'b1;
            end else if (sel_rdy) begin
                rsp_rdy = 1'b1;
                rsp_err = sel_err;
                rsp_dat = sel_dat;
            end else if (expire) begin
                rsp_rdy = 1'b1;
                rsp_err = 1'b1;
                to_hit  = 1'b1;
            end
        end
    end

    assign bus.pready_x  = rsp_rdy;
    assign bus.pslverr_x = rsp_err;
    assign bus.prdata_x  = rsp_dat;
    assign err_done      = rsp_rdy && rsp_err;

    // ---------------- transfer FSM ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.psel_en && !bus.penable) state_nxt = ST_SETUP;
            ST_SETUP:  if (!bus.psel_en)                state_nxt = ST_IDLE;
                       else if (bus.penable)            state_nxt = ST_ACCESS;
            ST_ACCESS: if (!bus.psel_en || rsp_rdy)     state_nxt = ST_IDLE;
            default:                                    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    apb_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .clr      (state != ST_ACCESS),
        .inc      ((state == ST_ACCESS) && !rsp_rdy),
        .expire   (expire)
    );

    // ---------------- sticky status ----------------
    // A clear coinciding with an error is applied first, so the new error
    // is the first thing recorded after the clear.
    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            stat_q <= '0;
        end else if (err_done) begin
            stat_q.err_cnt  <= sat_inc(stat_clr ? '0 : stat_q.err_cnt);
            stat_q.err_addr <= bus.paddr;
            stat_q.to_flag  <= (stat_clr ? 1'b0 : stat_q.to_flag) | to_hit;
        end else if (stat_clr) begin
            stat_q <= '0;
        end
    end

    assign err_cnt  = stat_q.err_cnt;
    assign err_addr = stat_q.err_addr;
    assign to_flag  = stat_q.to_flag;

endmodule

// File: tb/tb_apb_slv_ctrl.sv
// Bench for apb_slv_ctrl: acts as bridge and slaves, predicts each transfer's
// outcome from the address map and slave wait count, and tracks status in a model.
// Runs directed scenarios, then randomized transfers, counter saturation and mid-transfer reset.
module tb_apb_slv_ctrl;
    import apb_slv_ctrl_pkg::*;

    localparam int SLV_NUM = 4;
    localparam int TO      = 16;
    localparam int W       = APB_DATA_WIDTH;

    logic                   hclk     = 1'b0;
    logic                   hreset_n = 1'b0;
    logic                   stat_clr = 1'b0;
    logic [7:0]             err_cnt;
    logic [PADDR_WIDTH-1:0] err_addr;
    logic                   to_flag;

    apb_slv_ctrl_if #(.SLV_NUM(SLV_NUM)) bus ();

    apb_slv_ctrl #(
        .SLV_NUM      (SLV_NUM),
        .SLV_ADDR_LSB (12),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .bus      (bus),
        .stat_clr (stat_clr),
        .err_cnt  (err_cnt),
        .err_addr (err_addr),
        .to_flag  (to_flag)
    );

    always #5 hclk = ~hclk;

    int n_chk  = 0;
    int n_fail = 0;

    // status reference model
    int          m_cnt  = 0;
    logic [31:0] m_addr = '0;
    bit          m_flag = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit rand_clr(input int pct);
        return ($urandom_range(99, 0) < pct);
    endfunction

    task automatic drive_slaves(input int sel, input bit own, input bit rdy, input bit serr,
                                input logic [31:0] dat);
        for (int i = 0; i < SLV_NUM; i++) begin
            bus.pready_s[i]        = 1'($urandom_range(1, 0));
            bus.pslverr_s[i]       = 1'($urandom_range(1, 0));
            bus.prdata_s[i*W +: W] = $urandom;
        end
        if (own) begin
            bus.pready_s[sel]        = rdy;
            bus.pslverr_s[sel]       = serr;
            bus.prdata_s[sel*W +: W] = dat;
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_psel"},  64'(bus.psel_s),    64'd0);
        check_eq({tag, "_pen"},   64'(bus.penable_s), 64'd0);
        check_eq({tag, "_rdy"},   64'(bus.pready_x),  64'd0);
        check_eq({tag, "_err"},   64'(bus.pslverr_x), 64'd0);
        check_eq({tag, "_rdata"}, 64'(bus.prdata_x),  64'd0);
    endtask

    task automatic check_status();
        check_eq("err_cnt",  64'(err_cnt),  64'(m_cnt));
        check_eq("err_addr", 64'(err_addr), 64'(m_addr));
        check_eq("to_flag",  64'(to_flag),  64'(m_flag));
    endtask

    // Checks status for this cycle, applies this cycle's events to the model,
    // then steps to just after the next rising edge.
    task automatic cycle_end(input bit clr, input bit fin, input bit ferr, input bit fto,
                             input logic [31:0] addr);
        check_status();
        if (fin && ferr) begin
            if (clr) begin
                m_cnt  = 0;
                m_flag = 1'b0;
            end
            if (m_cnt < 255) m_cnt++;
            m_addr = addr;
            m_flag = m_flag | fto;
        end else if (clr) begin
            m_cnt  = 0;
            m_addr = '0;
            m_flag = 1'b0;
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_cycles(input int n, input int clr_pct);
        bit clr;
        for (int c = 0; c < n; c++) begin
            clr          = rand_clr(clr_pct);
            bus.psel_en  = 1'b0;
            bus.penable  = 1'b0;
            stat_clr     = clr;
            drive_slaves(0, 1'b0, 1'b0, 1'b0, '0);
            @(negedge hclk);
            check_quiet("idle");
            cycle_end(clr, 1'b0, 1'b0, 1'b0, '0);
        end
    endtask

    // One bridge transfer. d = ACCESS cycles the target slave keeps pready low.
    task automatic do_xfer(input logic [31:0] addr, input int d, input bit serr,
                           input logic [31:0] dat, input int clr_pct, input int force_clr_k);
        bit          mapped;
        int          idx;
        int          done_k;
        bit          exp_err;
        bit          exp_to;
        logic [31:0] exp_dat;
        logic [3:0]  exp_sel;
        bit          clr;
        bit          hit;

        mapped  = (addr >> 14) == 0;
        idx     = int'(addr[13:12]);
        exp_sel = mapped ? 4'(1 << idx) : 4'b0;
        if (!mapped) begin
            done_k = 1; exp_err = 1'b1; exp_dat = '0; exp_to = 1'b0;
        end else if (d < TO) begin
            done_k = d + 1; exp_err = serr; exp_dat = dat; exp_to = 1'b0;
        end else begin
            done_k = TO; exp_err = 1'b1; exp_dat = '0; exp_to = 1'b1;
        end

        // bridge setup request; controller still idle
        clr         = rand_clr(clr_pct);
        bus.psel_en = 1'b1;
        bus.penable = 1'b0;
        bus.paddr   = addr;
        stat_clr    = clr;
        drive_slaves(idx, 1'b0, 1'b0, 1'b0, '0);
        @(negedge hclk);
        check_quiet("req");
        cycle_end(clr, 1'b0, 1'b0, 1'b0, addr);

        // controller setup cycle
        clr         = rand_clr(clr_pct);
        bus.penable = 1'b1;
        stat_clr    = clr;
        drive_slaves(idx, 1'b0, 1'b0, 1'b0, '0);
        @(negedge hclk);
        check_eq("setup_psel", 64'(bus.psel_s),    64'(exp_sel));
        check_eq("setup_pen",  64'(bus.penable_s), 64'd0);
        check_eq("setup_rdy",  64'(bus.pready_x),  64'd0);
        check_eq("setup_err",  64'(bus.pslverr_x), 64'd0);
        check_eq("setup_rdat", 64'(bus.prdata_x),  64'd0);
        cycle_end(clr, 1'b0, 1'b0, 1'b0, addr);

        // access cycles
        for (int k = 1; k <= done_k; k++) begin
            clr      = (k == force_clr_k) ? 1'b1 : rand_clr(clr_pct);
            stat_clr = clr;
            hit      = (k == d + 1);
            drive_slaves(idx, mapped, hit, serr, hit ? dat : $urandom);
            @(negedge hclk);
            check_eq("acc_psel", 64'(bus.psel_s),    64'(exp_sel));
            check_eq("acc_pen",  64'(bus.penable_s), 64'(mapped));
            check_eq("acc_rdy",  64'(bus.pready_x),  64'(k == done_k));
            if (k == done_k) begin
                check_eq("acc_err",  64'(bus.pslverr_x), 64'(exp_err));
                check_eq("acc_rdat", 64'(bus.prdata_x),  64'(exp_dat));
            end
            cycle_end(clr, k == done_k, exp_err, exp_to, addr);
        end

        // bridge drops select after completion
        idle_cycles(1, clr_pct);
    endtask

    task automatic reset_mid_access();
        logic [31:0] addr;
        addr = 32'h0000_3010;
        bus.psel_en = 1'b1; bus.penable = 1'b0; bus.paddr = addr; stat_clr = 1'b0;
        drive_slaves(3, 1'b1, 1'b0, 1'b0, '0);
        @(negedge hclk);
        cycle_end(1'b0, 1'b0, 1'b0, 1'b0, addr);
        bus.penable = 1'b1;
        @(negedge hclk);
        cycle_end(1'b0, 1'b0, 1'b0, 1'b0, addr);
        @(negedge hclk);
        check_eq("rst_pre_psel", 64'(bus.psel_s), 64'h8);
        cycle_end(1'b0, 1'b0, 1'b0, 1'b0, addr);
        hreset_n = 1'b0;
        @(posedge hclk);
        #1;
        m_cnt = 0; m_addr = '0; m_flag = 1'b0;
        hreset_n = 1'b1;
        @(negedge hclk);
        check_quiet("rst_post");
        cycle_end(1'b0, 1'b0, 1'b0, 1'b0, addr);
        // penable still high: an idle controller must not start a new setup
        @(negedge hclk);
        check_quiet("rst_idle");
        cycle_end(1'b0, 1'b0, 1'b0, 1'b0, addr);
        idle_cycles(2, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          d;

        bus.psel_en   = 1'b0;
        bus.penable   = 1'b0;
        bus.paddr     = '0;
        bus.pready_s  = '0;
        bus.pslverr_s = '0;
        bus.prdata_s  = '0;
        repeat (3) @(posedge hclk);
        #1;
        @(negedge hclk);
        check_quiet("reset");
        check_status();
        @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        idle_cycles(2, 0);

        // directed scenarios
        do_xfer(32'h0000_1004, 0,    1'b0, 32'h1234_5678, 0, 0);
        do_xfer(32'h0000_2000, 3,    1'b0, 32'hA5A5_0001, 0, 0);
        do_xfer(32'h0000_8000, 0,    1'b0, 32'h0,         0, 0);
        check_eq("unmapped_cnt",  64'(err_cnt),  64'd1);
        check_eq("unmapped_addr", 64'(err_addr), 64'h8000);
        do_xfer(32'h0000_0040, 1000, 1'b0, 32'h0,         0, 0);
        check_eq("timeout_flag",  64'(to_flag),  64'd1);
        do_xfer(32'h0000_1ffc, 15,   1'b1, 32'hDEAD_BEEF, 0, 16);
        check_eq("late_slv_cnt",  64'(err_cnt),  64'd1);
        check_eq("late_slv_flag", 64'(to_flag),  64'd0);

        // randomized traffic
        for (int t = 0; t < 150; t++) begin
            a = $urandom;
            if ($urandom_range(3, 0) == 0) begin
                if (a[31:14] == '0) a[31] = 1'b1;
            end else begin
                a[31:14] = '0;
            end
            d = ($urandom_range(3, 0) == 0) ? $urandom_range(20, 14) : $urandom_range(6, 0);
            do_xfer(a, d, 1'($urandom_range(1, 0)), $urandom, 10, 0);
            idle_cycles($urandom_range(2, 0), 10);
        end

        // error counter saturation
        for (int t = 0; t < 260; t++) begin
            a = $urandom;
            a[31] = 1'b1;
            do_xfer(a, 0, 1'b0, '0, 0, 0);
        end
        check_eq("sat_cnt", 64'(err_cnt), 64'd255);

        reset_mid_access();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_slv_ctrl.md
# apb_slv_ctrl

- Controller on the APB side of the AHB-to-APB bridge.
- Decodes the bridge's `paddr` into one of up to four APB slave selects and tracks each APB transfer through setup and access.
- Returns the selected slave's `pready`/`pslverr`/`prdata` to the bridge as `pready_x`/`pslverr_x`/`prdata_x`.
- Guarantees completion: unmapped addresses get an immediate error; a slave that holds `pready` low too long is aborted with an error.
- Keeps sticky error status for software.

## Interface
Parameters:
- `SLV_NUM`, 4: number of mapped slaves (1..4).
- `SLV_ADDR_LSB`, 12: lowest address bit of the 2-bit slave index.
- `TIMEOUT_CYC`, 16: maximum access-phase cycles with `pready` low. 0 disables the timeout. Counter width is `$clog2(TIMEOUT_CYC+1)`.

Ports:
- `hclk` in 1: single clock.
- `hreset_n` in 1: synchronous, active-low reset.
- `psel_en` in 1: bridge APB select.
- `penable` in 1: bridge APB enable.
- `paddr` in `PADDR_WIDTH`: bridge APB address.
- `pready_x` out 1: completion to bridge.
- `pslverr_x` out 1: error to bridge.
- `prdata_x` out `APB_DATA_WIDTH`: read data to bridge.
- `psel_s` out `SLV_NUM`: one-hot slave selects.
- `penable_s` out 1: enable to the selected slave.
- `pready_s` in `SLV_NUM`: per-slave ready.
- `pslverr_s` in `SLV_NUM`: per-slave error.
- `prdata_s` in `SLV_NUM*APB_DATA_WIDTH`: per-slave read data; slave i occupies bits `[i*W +: W]`.
- `stat_clr` in 1: clears status.
- `err_cnt` out 8: saturating count of error completions.
- `err_addr` out `PADDR_WIDTH`: `paddr` of the most recent error.
- `to_flag` out 1: sticky flag, set on any timeout.

## Operation
- Decode: `idx = paddr[SLV_ADDR_LSB +: 2]`.
  - Mapped iff `idx < SLV_NUM` and all `paddr` bits above `SLV_ADDR_LSB+1` are 0.
  - `psel_s[idx] = psel_en & mapped & (state != IDLE)`.
  - `penable_s = penable & mapped & (state == ACCESS)`.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when `psel_en & ~penable`.
  - SETUP -> ACCESS when `penable`. SETUP -> IDLE if `psel_en` drops.
  - ACCESS -> IDLE on completion, or if `psel_en` drops.
- Completion, evaluated only in ACCESS with `penable=1`, in priority order:
  1. Unmapped: `pready_x=1`, `pslverr_x=1`, `prdata_x=0`, in the first ACCESS cycle. No `psel_s` is ever asserted.
  2. `pready_s[idx]=1`: `pready_x=1`, `pslverr_x=pslverr_s[idx]`, `prdata_x=prdata_s[idx]`.
  3. Timeout (`TIMEOUT_CYC>0` and `to_cnt == TIMEOUT_CYC-1`): `pready_x=1`, `pslverr_x=1`, `prdata_x=0`.
- Outside ACCESS, `pready_x`, `pslverr_x` and `prdata_x` are 0.
- `to_cnt`:
  - Cleared in IDLE and SETUP.
  - Increments each ACCESS cycle with no completion.
  - Saturates at `TIMEOUT_CYC`.
- Status update on each error completion:
  - `err_cnt` increments, saturating at 255.
  - `err_addr <= paddr`.
  - `to_flag` sets if the cause was a timeout.
- `stat_clr` zeroes all status. When it coincides with an error completion, the clear applies first: `err_cnt=1`, and `err_addr`/`to_flag` reflect the new error.

## Timing
- Reset: state IDLE, `to_cnt=0`, `err_cnt=0`, `err_addr=0`, `to_flag=0`. With the FSM in IDLE, all outputs are 0.
- The response path is combinational from `pready_s`/`pslverr_s`/`prdata_s` to `*_x`, because the bridge samples `pready_x` in the same cycle.
- Latency: zero added wait states. Fastest transfer is one SETUP cycle plus one ACCESS cycle.
- A timeout response occurs in ACCESS cycle number `TIMEOUT_CYC`.
- Slave completion in the same cycle as a timeout: the slave response wins and no timeout is recorded.
- Reset asserted mid-transfer: the FSM returns to IDLE and all selects drop on the next edge.
- Back-to-back transfers pass through IDLE for at least one cycle, because the bridge drops `psel_en` after each completion.

## Structure
- Shared defines: `PADDR_WIDTH`, `APB_DATA_WIDTH`. Add `APB_SLV_IDX_WIDTH` (2) to the same defines file.
- State encodings are local parameters of this block.
- One sub-module, `apb_timeout_cnt`: the saturating access-phase counter, with `clr`, `inc` and an `expire` output.

## Test plan
- Mapped write to slave 1 (`paddr=0x1004`), with `pready_s[1]=1` in the first ACCESS cycle -> `psel_s=4'b0010` for 2 cycles, `pready_x=1`, `pslverr_x=0`, `err_cnt` stays 0.
- Read from slave 2 (`paddr=0x2000`), with `pready_s[2]` low for 3 cycles and `prdata_s[2]=0xA5A5_0001` -> `pready_x` in ACCESS cycle 4, `prdata_x=0xA5A5_0001`.
- Unmapped `paddr=0x8000` with `SLV_NUM=4` (upper bits nonzero) -> `psel_s=0` throughout, `pready_x=pslverr_x=1` in the first ACCESS cycle, `err_cnt=1`, `err_addr=0x8000`.
- Slave 0 holds `pready_s[0]` low indefinitely -> `pready_x=pslverr_x=1` in ACCESS cycle 16, `to_flag=1`, FSM returns to IDLE.
- Slave asserts `pready_s` with `pslverr_s` in ACCESS cycle 16, with `stat_clr` pulsed the same cycle -> no timeout, `err_cnt=1`, `to_flag=0`.
- `hreset_n` low during ACCESS -> next cycle `psel_s=0`, state IDLE, all status 0.
